wb_commit: RTL and testbench

Parametrised writeback/commit stage for the LoongArch pipeline, placed between the MEM→WB interface and the register file / CSR unit. It owns its own input register with a valid/allow-in handshake. It stalls for a configurable CSR read latency, priority-encodes a generic exception bus into ecode/esubcode, and produces single-cycle commit, flush and bypass information plus a retire counter.

---
 rtl/wb_commit.sv | 145 ++++++++++++++
 tb/tb_wb_commit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit.sv
// Writeback/commit stage: holds one instruction from MEM, waits out the CSR read
// latency, encodes exceptions and emits single-cycle commit, flush and bypass info.
module wb_commit #(
  parameter int EBUS_W = 16,
  parameter logic [EBUS_W*6-1:0] ECODE_TAB = {
    6'h12, 6'h0F, 6'h04, 6'h02, 6'h01, 6'h0E, 6'h0D, 6'h09,
    6'h08, 6'h0C, 6'h0B, 6'h07, 6'h03, 6'h3F, 6'h08, 6'h00},
  parameter int ESUB_BIT = 7,
  parameter int CSR_LAT  = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_allow,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_result,
  input  logic              in_rf_we,
  input  logic [4:0]        in_rf_waddr,
  input  logic              in_res_from_csr,
  input  logic              in_ertn,
  input  logic [EBUS_W-1:0] in_ebus,
  input  logic [31:0]       csr_rvalue,
  output logic              csr_re,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic              ex_commit,
  output logic              ertn_commit,
  output logic [5:0]        ex_ecode,
  output logic [8:0]        ex_esubcode,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_vaddr,
  output logic              flush,
  output logic              byp_valid,
  output logic              byp_busy,
  output logic [4:0]        byp_waddr,
  output logic [31:0]       byp_wdata,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [31:0]       debug_wb_pc,
  output logic [3:0]        debug_wb_rf_we,
  output logic [4:0]        debug_wb_rf_wnum,
  output logic [31:0]       debug_wb_rf_wdata,
  output logic [1:0]        debug_wb_state
);

  localparam int IDX_W = (EBUS_W > 1) ? $clog2(EBUS_W) : 1;
  localparam logic [2:0] CNT_INIT = (CSR_LAT > 0) ? 3'(CSR_LAT - 1) : 3'd0;
  localparam bit HAS_LAT = (CSR_LAT > 0);

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_WAIT = 2'd1, S_READY = 2'd2} state_e;

  state_e            state_q;
  logic [2:0]        cnt_q;
  logic [31:0]       pc_q, result_q;
  logic              rf_we_q, res_csr_q, ertn_q;
  logic [4:0]        waddr_q;
  logic [EBUS_W-1:0] ebus_q;
  logic [CNT_W-1:0]  retire_q;

  logic              commit, exc, cap;
  logic [IDX_W-1:0]  sel_idx;
  logic [31:0]       wdata_sel;

  assign commit   = (state_q == S_READY);
  assign exc      = |ebus_q;
  assign flush    = ex_commit | ertn_commit;
  // A flushing commit must not accept a new instruction in the same cycle.
  assign in_allow = (state_q == S_EMPTY) | (commit & ~exc & ~ertn_q);
  assign cap      = in_valid & in_allow;

  // Lowest set bit wins.
  always_comb begin
    sel_idx = '0;
    for (int i = EBUS_W - 1; i >= 0; i--) begin
      if (ebus_q[i]) sel_idx = IDX_W'(i);
    end
  end

  assign wdata_sel   = res_csr_q ? csr_rvalue : result_q;
  assign ex_commit   = commit & exc;
  assign ertn_commit = commit & ~exc & ertn_q;
  assign rf_we       = commit & ~exc & rf_we_q;
  assign rf_waddr    = rf_we ? waddr_q : 5'd0;
  assign rf_wdata    = rf_we ? wdata_sel : 32'd0;
  assign ex_ecode    = ex_commit ? ECODE_TAB[int'(sel_idx) * 6 +: 6] : 6'd0;
  assign ex_esubcode = (ex_commit && sel_idx == IDX_W'(ESUB_BIT)) ? 9'h001 : 9'h000;
  assign ex_pc       = ex_commit ? pc_q : 32'd0;
  assign ex_vaddr    = ex_commit ? result_q : 32'd0;
  assign csr_re      = (state_q == S_WAIT) | (commit & res_csr_q);

  assign byp_valid = (state_q != S_EMPTY) & rf_we_q & ~exc;
  assign byp_busy  = byp_valid & ((state_q == S_WAIT) | res_csr_q);
  assign byp_waddr = byp_valid ? waddr_q : 5'd0;
  assign byp_wdata = (byp_valid & ~byp_busy) ? result_q : 32'd0;

  assign retire_cnt        = retire_q;
  assign debug_wb_pc       = (commit & ~exc) ? pc_q : 32'd0;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
  assign debug_wb_state    = state_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_EMPTY;
      cnt_q     <= 3'd0;
      pc_q      <= 32'd0;
      result_q  <= 32'd0;
      rf_we_q   <= 1'b0;
      waddr_q   <= 5'd0;
      res_csr_q <= 1'b0;
      ertn_q    <= 1'b0;
      ebus_q    <= '0;
      retire_q  <= '0;
    end else begin
      if (cap) begin
        pc_q      <= in_pc;
        result_q  <= in_result;
        rf_we_q   <= in_rf_we;
        waddr_q   <= in_rf_waddr;
        res_csr_q <= in_res_from_csr;
        ertn_q    <= in_ertn;
        ebus_q    <= in_ebus;
        if (HAS_LAT && in_res_from_csr && in_ebus == '0) begin
          state_q <= S_WAIT;
          cnt_q   <= CNT_INIT;
        end else begin
          state_q <= S_READY;
        end
      end else begin
        case (state_q)
          S_WAIT: begin
            if (cnt_q == 3'd0) state_q <= S_READY;
            else               cnt_q   <= cnt_q - 3'd1;
          end
          S_READY: state_q <= S_EMPTY;
          default: state_q <= S_EMPTY;
        endcase
      end
      if (commit && !exc) retire_q <= retire_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit with CSR_LAT=2 and a 4-bit retire counter.
module tb_wb_commit;

  localparam int EBUS_W = 16;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic              in_valid, in_allow;
  logic [31:0]       in_pc, in_result;
  logic              in_rf_we;
  logic [4:0]        in_rf_waddr;
  logic              in_res_from_csr, in_ertn;
  logic [EBUS_W-1:0] in_ebus;
  logic [31:0]       csr_rvalue;
  logic              csr_re, rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;
  logic              ex_commit, ertn_commit;
  logic [5:0]        ex_ecode;
  logic [8:0]        ex_esubcode;
  logic [31:0]       ex_pc, ex_vaddr;
  logic              flush, byp_valid, byp_busy;
  logic [4:0]        byp_waddr;
  logic [31:0]       byp_wdata;
  logic [CNT_W-1:0]  retire_cnt;
  logic [31:0]       debug_wb_pc;
  logic [3:0]        debug_wb_rf_we;
  logic [4:0]        debug_wb_rf_wnum;
  logic [31:0]       debug_wb_rf_wdata;
  logic [1:0]        debug_wb_state;

  int n_vec = 0;
  int n_err = 0;

  wb_commit #(.EBUS_W(EBUS_W), .ESUB_BIT(7), .CSR_LAT(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_allow(in_allow),
    .in_pc(in_pc), .in_result(in_result),
    .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr),
    .in_res_from_csr(in_res_from_csr), .in_ertn(in_ertn),
    .in_ebus(in_ebus), .csr_rvalue(csr_rvalue), .csr_re(csr_re),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ex_commit(ex_commit), .ertn_commit(ertn_commit),
    .ex_ecode(ex_ecode), .ex_esubcode(ex_esubcode),
    .ex_pc(ex_pc), .ex_vaddr(ex_vaddr), .flush(flush),
    .byp_valid(byp_valid), .byp_busy(byp_busy),
    .byp_waddr(byp_waddr), .byp_wdata(byp_wdata),
    .retire_cnt(retire_cnt),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .debug_wb_state(debug_wb_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    in_valid = 1'b0; in_pc = 32'd0; in_result = 32'd0; in_rf_we = 1'b0;
    in_rf_waddr = 5'd0; in_res_from_csr = 1'b0; in_ertn = 1'b0; in_ebus = '0;
  endtask

  task automatic set_alu(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] data);
    set_idle();
    in_valid = 1'b1; in_pc = pc; in_result = data; in_rf_we = 1'b1; in_rf_waddr = wa;
  endtask

  task automatic set_csr(input logic [4:0] wa);
    set_idle();
    in_valid = 1'b1; in_pc = 32'h1c00_0200; in_rf_we = 1'b1; in_rf_waddr = wa;
    in_res_from_csr = 1'b1;
  endtask

  // Capture one faulting instruction and check the exception commit it produces.
  task automatic do_exc(input logic [EBUS_W-1:0] eb, input logic [5:0] ecode,
                        input logic [8:0] esub, input logic [3:0] cnt_before);
    set_alu(32'h1c00_0100, 5'd9, 32'hbad0_0004);
    in_ebus = eb;
    cyc();
    set_idle();
    #1;
    chk("exc_commit", 32'(ex_commit), 32'd1);
    chk("exc_ecode", 32'(ex_ecode), 32'(ecode));
    chk("exc_esub", 32'(ex_esubcode), 32'(esub));
    chk("exc_rf_we", 32'(rf_we), 32'd0);
    chk("exc_flush", 32'(flush), 32'd1);
    chk("exc_pc", ex_pc, 32'h1c00_0100);
    chk("exc_vaddr", ex_vaddr, 32'hbad0_0004);
    chk("exc_byp", 32'(byp_valid), 32'd0);
    chk("exc_allow", 32'(in_allow), 32'd0);
    cyc();
    chk("exc_cnt", 32'(retire_cnt), 32'(cnt_before));
    chk("exc_ecode_idle", 32'(ex_ecode), 32'd0);
    chk("exc_commit_idle", 32'(ex_commit), 32'd0);
  endtask

  initial begin
    set_idle();
    csr_rvalue = 32'hdead_beef;
    resetn = 1'b0;
    cyc(); cyc();
    resetn = 1'b1;
    #1;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_cnt", 32'(retire_cnt), 32'd0);
    chk("rst_csr_re", 32'(csr_re), 32'd0);
    chk("rst_byp", 32'(byp_valid), 32'd0);
    chk("rst_allow", 32'(in_allow), 32'd1);

    // Four back-to-back ALU writes.
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) set_alu(32'h1c00_0000 + 32'(4 * i), 5'(i), 32'(8'h11 * i));
      else        set_idle();
      #1;
      if (i <= 4) chk("strm_allow", 32'(in_allow), 32'd1);
      if (i >= 2) begin
        chk("strm_we", 32'(rf_we), 32'd1);
        chk("strm_wa", 32'(rf_waddr), 32'(i - 1));
        chk("strm_wd", rf_wdata, 32'(8'h11 * (i - 1)));
        chk("strm_dbg_we", 32'(debug_wb_rf_we), 32'hf);
      end
      cyc();
    end
    chk("strm_cnt", 32'(retire_cnt), 32'd4);
    chk("strm_idle_we", 32'(rf_we), 32'd0);

    // CSR read with two wait cycles.
    set_csr(5'd5);
    cyc();
    set_idle();
    for (int w = 0; w < 2; w++) begin
      #1;
      chk("csr_allow", 32'(in_allow), 32'd0);
      chk("csr_re", 32'(csr_re), 32'd1);
      chk("csr_busy", 32'(byp_busy), 32'd1);
      chk("csr_we_wait", 32'(rf_we), 32'd0);
      cyc();
    end
    chk("csr_we", 32'(rf_we), 32'd1);
    chk("csr_wa", 32'(rf_waddr), 32'd5);
    chk("csr_wd", rf_wdata, 32'hdead_beef);
    chk("csr_allow_rdy", 32'(in_allow), 32'd1);
    cyc();
    chk("csr_cnt", 32'(retire_cnt), 32'd5);

    // Exceptions: ADEM wins over IPE; INE over FPE; FPE alone.
    do_exc(16'h0480, 6'h08, 9'h001, 4'd5);
    do_exc(16'h8200, 6'h0D, 9'h000, 4'd5);
    do_exc(16'h8000, 6'h12, 9'h000, 4'd5);

    // ertn.
    set_idle();
    in_valid = 1'b1; in_ertn = 1'b1; in_pc = 32'h1c00_0300;
    cyc();
    set_idle();
    #1;
    chk("ertn_commit", 32'(ertn_commit), 32'd1);
    chk("ertn_flush", 32'(flush), 32'd1);
    chk("ertn_we", 32'(rf_we), 32'd0);
    chk("ertn_ex", 32'(ex_commit), 32'd0);
    cyc();
    chk("ertn_cnt", 32'(retire_cnt), 32'd6);
    chk("ertn_pulse", 32'(ertn_commit), 32'd0);

    // Reset while waiting on a CSR read, then a fresh instruction.
    set_csr(5'd6);
    cyc();
    set_idle();
    #1;
    chk("rw_csr_re", 32'(csr_re), 32'd1);
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    #1;
    chk("rw_csr_re0", 32'(csr_re), 32'd0);
    chk("rw_we", 32'(rf_we), 32'd0);
    chk("rw_byp", 32'(byp_valid), 32'd0);
    chk("rw_cnt", 32'(retire_cnt), 32'd0);
    chk("rw_flush", 32'(flush), 32'd0);
    set_alu(32'h1c00_0400, 5'd7, 32'h77);
    cyc();
    set_idle();
    #1;
    chk("rw_new_we", 32'(rf_we), 32'd1);
    chk("rw_new_wd", rf_wdata, 32'h77);
    chk("rw_new_pc", debug_wb_pc, 32'h1c00_0400);
    cyc();
    chk("rw_new_cnt", 32'(retire_cnt), 32'd1);

    // Counter wrap: 14 more commits reach 15, then one more wraps to 0.
    for (int i = 0; i < 14; i++) begin
      set_alu(32'h1c00_1000, 5'd3, 32'(i));
      cyc();
    end
    set_idle();
    cyc();
    chk("wrap_max", 32'(retire_cnt), 32'd15);
    set_alu(32'h1c00_2000, 5'd4, 32'h44);
    cyc();
    set_idle();
    cyc();
    chk("wrap_zero", 32'(retire_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
